// File: rtl/uart_tx_param.sv
// Purpose   : parametrised UART transmitter; start bit, DATA_BITS data (LSB first), optional parity, 1-2 stop bits.
// Latency   : TX falls the cycle after an accepting edge; frame lasts F = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
// Backpress.: ready low for the whole frame; start while busy is dropped (no queuing), one idle cycle between frames.
//
// Ports:
//   CLK, RST_N  : rising-edge clock, asynchronous active-low reset
//   start       : transmit request, accepted only when ready is high
//   message     : word to send, [DATA_BITS:1], bit 1 goes out first
//   ready/busy  : idle / frame in progress (busy == ~ready)
//   TX          : registered serial line, idle high
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic [DATA_BITS:1] message,
    output logic               ready,
    output logic               busy,
    output logic               TX
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_BITS);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);
    // The bit counter is reused to count stop bits (DATA_BITS >= 5 gives room).
    localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [BW-1:0]        baud_cnt;
    logic [NW-1:0]        bit_cnt;
    logic                 baud_wrap;

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // TX is always loaded with the level of the bit being entered, so the
    // line changes on the same edge as the state and never glitches.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            shreg    <= '0;
            par_bit  <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            TX       <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= message;
                        // odd: bit makes total ones odd; even: total ones even
                        par_bit  <= (PARITY == 1) ? ~^message : ^message;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= START;
                        TX       <= 1'b0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        TX       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                TX    <= par_bit;
                            end else begin
                                state <= STOP;
                                TX    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + NW'(1);
                            shreg   <= shreg >> 1;
                            // shreg[1] becomes the new LSB after the shift
                            TX      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                PAR: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        TX       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + NW'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    TX    <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five parameter sets side by side, each with a
// queue-based frame model; table-driven frames, back-to-back, reset abort,
// and randomized start/message traffic.
module tb_uart_tx_param;

    localparam int NCFG = 5;

    // cfg0: 8/4/none/1  cfg1: 8/4/even/1  cfg2: 8/4/odd/1  cfg3: 7/3/none/2  cfg4: 8/2/none/1
    function automatic int db_of(input int g);
        return (g == 3) ? 7 : 8;
    endfunction
    function automatic int cpb_of(input int g);
        return (g == 3) ? 3 : (g == 4) ? 2 : 4;
    endfunction
    function automatic int par_of(input int g);
        return (g == 1) ? 2 : (g == 2) ? 1 : 0;
    endfunction
    function automatic int sb_of(input int g);
        return (g == 3) ? 2 : 1;
    endfunction

    logic            CLK   = 1'b0;
    logic            RST_N = 1'b0;
    logic [NCFG-1:0] start_v = '0;
    logic [NCFG-1:0] tx_v, rdy_v, busy_v;
    logic [8:0]      msg_v [NCFG];

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int DB  = db_of(g);
        localparam int CPB = cpb_of(g);
        localparam int PR  = par_of(g);
        localparam int SB  = sb_of(g);

        uart_tx_param #(
            .DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY(PR), .STOP_BITS(SB)
        ) dut (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .start  (start_v[g]),
            .message(msg_v[g][DB-1:0]),
            .ready  (rdy_v[g]),
            .busy   (busy_v[g]),
            .TX     (tx_v[g])
        );

        // Reference: on acceptance, the whole frame is laid out as a list of
        // per-cycle line levels; each cycle afterwards consumes one entry.
        logic       lvl_q [$];
        logic       lv [$];
        logic       mbusy  = 1'b0;
        logic       exp_tx = 1'b1;
        logic [8:0] m;
        int         ones;

        always @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                lvl_q.delete();
                mbusy  = 1'b0;
                exp_tx = 1'b1;
            end else begin
                if (!mbusy && start_v[g]) begin
                    m = msg_v[g];
                    lv.delete();
                    lv.push_back(1'b0);
                    for (int i = 0; i < DB; i++) lv.push_back(m[i]);
                    if (PR != 0) begin
                        ones = $countones(m[DB-1:0]);
                        if (PR == 2) lv.push_back(ones[0]);
                        else         lv.push_back(~ones[0]);
                    end
                    for (int s = 0; s < SB; s++) lv.push_back(1'b1);
                    foreach (lv[i])
                        for (int r = 0; r < CPB; r++) lvl_q.push_back(lv[i]);
                end
                if (lvl_q.size() > 0) begin
                    exp_tx = lvl_q.pop_front();
                    mbusy  = 1'b1;
                end else begin
                    exp_tx = 1'b1;
                    mbusy  = 1'b0;
                end
            end
        end

        always @(negedge CLK) begin
            chk($sformatf("cfg%0d tx", g),    tx_v[g],   exp_tx);
            chk($sformatf("cfg%0d ready", g), rdy_v[g],  !mbusy);
            chk($sformatf("cfg%0d busy", g),  busy_v[g], mbusy);
        end
    end

    typedef struct {
        int         cfg;
        logic [8:0] msg;
        int         exp_f;     // cycles ready stays low
        int         nbits;     // bits in the frame
        logic [15:0] exp_bits; // bit i = line level of frame bit i
    } vec_t;

    vec_t vecs [8];

    task automatic wait_ready(input int c);
        int n;
        n = 0;
        @(negedge CLK);
        while (rdy_v[c] !== 1'b1 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) chk($sformatf("cfg%0d wait ready timeout", c), rdy_v[c], 1);
    endtask

    // Sends one frame, checks mid-bit levels and ready-low length, and
    // disturbs start/message mid-frame to confirm they are ignored.
    task automatic run_vec(input vec_t v);
        int c, cpb, lowcnt, half, b;
        c = v.cfg;
        cpb = cpb_of(c);
        lowcnt = 0;
        half = v.exp_f / 2;
        wait_ready(c);
        msg_v[c]   = v.msg;
        start_v[c] = 1'b1;
        @(posedge CLK);
        #2;
        start_v[c] = 1'b0;
        msg_v[c]   = ~v.msg;
        for (int j = 0; j < v.exp_f; j++) begin
            @(negedge CLK);
            if (rdy_v[c] == 1'b0) lowcnt++;
            b = j / cpb;
            if ((j % cpb) == (cpb / 2) && b < v.nbits)
                chk($sformatf("vec cfg%0d bit%0d", c, b), tx_v[c], v.exp_bits[b]);
            start_v[c] = (j == half);
        end
        chk($sformatf("vec cfg%0d ready low cycles", c), lowcnt, v.exp_f);
        @(negedge CLK);
        chk($sformatf("vec cfg%0d ready back", c), rdy_v[c], 1);
        repeat (3) begin
            @(negedge CLK);
            chk($sformatf("vec cfg%0d no extra frame", c), tx_v[c], 1);
        end
    endtask

    task automatic run_cont();
        int   falls [3];
        int   nf, n;
        logic prev;
        wait_ready(3);
        msg_v[3]   = 9'h07F;
        start_v[3] = 1'b1;
        nf = 0; n = 0; prev = 1'b1;
        while (nf < 3 && n < 200) begin
            @(negedge CLK);
            if (prev && !tx_v[3]) begin
                falls[nf] = n;
                nf++;
            end
            prev = tx_v[3];
            n++;
        end
        start_v[3] = 1'b0;
        chk("cont frames seen", nf, 3);
        if (nf == 3) begin
            chk("cont first start bit", falls[0], 0);
            chk("cont period 1", falls[1] - falls[0], 31);
            chk("cont period 2", falls[2] - falls[1], 31);
        end
    endtask

    task automatic run_reset_abort();
        wait_ready(0);
        msg_v[0]   = 9'h095;
        start_v[0] = 1'b1;
        @(posedge CLK);
        #2;
        start_v[0] = 1'b0;
        // cycle 17 after acceptance lies inside DATA bit 3 (a 0 for 0x95)
        repeat (18) @(negedge CLK);
        chk("abort pre-reset tx", tx_v[0], 0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("abort tx async high", tx_v[0], 1);
        chk("abort ready async high", rdy_v[0], 1);
        chk("abort busy async low", busy_v[0], 0);
        repeat (3) @(negedge CLK);
        RST_N      = 1'b1;
        msg_v[0]   = 9'h095;
        start_v[0] = 1'b1;
        @(negedge CLK);
        chk("first edge after reset accepts tx", tx_v[0], 0);
        chk("first edge after reset accepts ready", rdy_v[0], 0);
        start_v[0] = 1'b0;
        run_vec(vecs[0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NCFG; c++) msg_v[c] = '0;
        vecs[0] = '{0, 9'h095, 40, 10, 16'h032A};
        vecs[1] = '{1, 9'h095, 44, 11, 16'h052A};
        vecs[2] = '{2, 9'h095, 44, 11, 16'h072A};
        vecs[3] = '{3, 9'h07F, 30, 10, 16'h03FE};
        vecs[4] = '{4, 9'h000, 20, 10, 16'h0200};
        vecs[5] = '{1, 9'h003, 44, 11, 16'h0406};
        vecs[6] = '{2, 9'h000, 44, 11, 16'h0600};
        vecs[7] = '{3, 9'h055, 30, 10, 16'h03AA};

        repeat (2) @(negedge CLK);
        chk("reset tx", tx_v, 5'h1F);
        chk("reset ready", rdy_v, 5'h1F);
        chk("reset busy", busy_v, 5'h00);
        RST_N = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);
        run_cont();
        run_reset_abort();

        for (int n = 0; n < 600; n++) begin
            @(negedge CLK);
            for (int c = 0; c < NCFG; c++) begin
                start_v[c] = ($urandom_range(0, 3) == 0);
                msg_v[c]   = 9'($urandom);
            end
            if (n == 300) begin
                #2 RST_N = 1'b0;
                #2 RST_N = 1'b1;
            end
        end
        start_v = '0;
        repeat (60) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the successor to the fixed 8-bit `sender`. It serialises one DATA_BITS-wide word per frame onto `TX`: start bit, data LSB first, optional parity bit, then 1 or 2 stop bits. Bit period is set by a clock divider. A start/ready handshake lets the upstream logic queue words back-to-back. It sits between the core datapath and the board TX pin.

## Interface
Parameters:
- DATA_BITS, 8, word width; legal range 5–9
- CLKS_PER_BIT, 16, CLK cycles per serial bit; must be ≥ 2
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- start  in  1  transmit request; sampled on each rising edge
- message  in  DATA_BITS  word to send, indexed [DATA_BITS:1]; bit 1 is sent first
- ready  out  1  high when a request can be accepted (IDLE)
- busy  out  1  high while a frame is in progress; equals ~ready
- TX  out  1  serial line, idle high

## Operation
- States: IDLE → START → DATA → PAR → STOP → IDLE.
  - PAR is skipped when PARITY = 0.
  - STOP lasts STOP_BITS bit periods.
- Accept: a rising edge with `start`=1 and `ready`=1.
  - `message` is captured into a shift register on that edge.
  - Parity is computed from the captured word.
  - Later changes on `message` have no effect on the frame.
- `start` while busy: ignored; no queuing and no error flag.
- Baud counter: counts 0..CLKS_PER_BIT-1 within each bit. The state or bit advances on the wrap.
- Bit counter: counts data bits 0..DATA_BITS-1. DATA exits after bit DATA_BITS-1 completes.
- TX value per state:
  - START: 0.
  - DATA: the current shift-register LSB.
  - PAR: odd mode gives ~^data; even mode gives ^data.
  - STOP and IDLE: 1.
- `TX` is registered (glitch-free output).
- Reset value of every output: `TX`=1, `ready`=1, `busy`=0. Counters are cleared and the state is IDLE.
- Reset mid-frame: the frame is aborted at once.
  - `TX` goes high asynchronously.
  - No partial frame resumes after release.

## Timing
- Frame length, in CLK cycles: F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT.
- Acceptance edge k:
  - `TX` falls, and `ready` falls / `busy` rises, in the cycle after edge k.
  - The start bit is visible for exactly CLKS_PER_BIT cycles.
- Each subsequent bit is held for exactly CLKS_PER_BIT cycles.
- `ready` returns high after edge k+F, i.e. after the last stop-bit cycle.
  - The earliest next acceptance is edge k+F+1.
  - With `start` held high continuously, frames repeat every F+1 cycles, separated by one idle-high cycle.
- Reset deassertion: the first acceptance is possible on the first rising edge with RST_N high.
- Width rules:
  - The baud counter is $clog2(CLKS_PER_BIT) bits.
  - The bit counter is $clog2(DATA_BITS) bits.
  - Neither counter is allowed to overflow past its terminal value.

## Test plan
- DATA_BITS=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; send message=8'b1001_0101.
  - Required TX: 0, then 1,0,1,0,1,0,0,1, then 1, each held 4 cycles.
  - `ready` is low for exactly 40 cycles.
- Same word with PARITY=2 (even): parity bit = 0, F=44. With PARITY=1 (odd): parity bit = 1.
- DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=3, message=7'h7F, `start` held high for 3 frames.
  - Required TX per frame: 0, seven 1s, then two 1s.
  - Frames start every 31 cycles.
- `start` pulsed mid-frame and `message` changed mid-frame: the current frame is unchanged and no extra frame is sent.
- RST_N pulsed low during DATA bit 3: `TX`=1 and `ready`=1 immediately, with no further transitions.
  - A new request after release produces a clean full frame.
- CLKS_PER_BIT=2 (minimum): message=8'h00 yields 18 low cycles followed by 2 high cycles.
